// File: rtl/signal_head_sequencer.sv
// Lamp-head sequencer: turns per-approach grants into red/yellow/green lamp drive,
// enforcing minimum green, yellow, all-red clearance, NS/E interlock and a sticky conflict fault.
module signal_head_sequencer #(
    parameter int MIN_GREEN      = 3,
    parameter int YELLOW_CYCLES  = 4,
    parameter int ALL_RED_CYCLES = 2,
    parameter int FLASH_PERIOD   = 8,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       n_go,
    input  logic       s_go,
    input  logic       e_go,
    output logic [2:0] n_lamp,
    output logic [2:0] s_lamp,
    output logic [2:0] e_lamp,
    output logic       fault
);

    typedef enum logic [1:0] {ST_RED, ST_GREEN, ST_YELLOW, ST_FAULT} state_t;

    localparam logic [CNT_W-1:0] L_MG   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] L_YC   = CNT_W'(YELLOW_CYCLES);
    localparam logic [CNT_W-1:0] L_AR   = CNT_W'(ALL_RED_CYCLES);
    localparam logic [CNT_W-1:0] L_FPM1 = CNT_W'(FLASH_PERIOD - 1);
    localparam logic [CNT_W-1:0] L_FH   = CNT_W'(FLASH_PERIOD / 2);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Index 0 = north, 1 = south, 2 = east
    state_t             r_st    [3];
    logic [CNT_W-1:0]   r_tmr   [3];
    logic [2:0]         r_lamp  [3];
    logic [CNT_W-1:0]   r_clr_ns;
    logic [CNT_W-1:0]   r_clr_ew;
    logic [CNT_W-1:0]   r_flash;
    logic               r_fault;

    state_t             w_st_nx   [3];
    logic [CNT_W-1:0]   w_tmr_nx  [3];
    logic [2:0]         w_lamp_nx [3];
    logic [2:0]         w_go;
    logic [2:0]         w_act;
    logic [2:0]         w_elig;
    logic               w_ns_act;
    logic               w_ew_act;
    logic               w_fault_nx;
    logic [CNT_W-1:0]   w_flash_nx;
    logic [CNT_W-1:0]   w_clr_ns_nx;
    logic [CNT_W-1:0]   w_clr_ew_nx;

    function automatic logic [2:0] f_lamp(input state_t st);
        case (st)
            ST_GREEN:  f_lamp = LAMP_GRN;
            ST_YELLOW: f_lamp = LAMP_YEL;
            default:   f_lamp = LAMP_RED;
        endcase
    endfunction

    always_comb begin
        w_go       = {e_go, s_go, n_go};
        w_fault_nx = r_fault | (e_go & (n_go | s_go));
        for (int i = 0; i < 3; i++) begin
            w_act[i] = (r_st[i] == ST_GREEN) || (r_st[i] == ST_YELLOW);
        end
        w_ns_act = w_act[0] | w_act[1];
        w_ew_act = w_act[2];

        w_elig[0] = n_go & ~w_ew_act & (r_clr_ew >= L_AR);
        w_elig[1] = s_go & ~w_ew_act & (r_clr_ew >= L_AR);
        // NS takes precedence if both axes qualify on the same edge
        w_elig[2] = e_go & ~w_ns_act & (r_clr_ns >= L_AR) & ~(w_elig[0] | w_elig[1]);

        w_flash_nx = LAMP_OFF[0] ? '0 : '0;
        if (r_fault) begin
            w_flash_nx = (r_flash == L_FPM1) ? '0 : r_flash + 1'b1;
        end

        for (int i = 0; i < 3; i++) begin
            w_st_nx[i]  = r_st[i];
            w_tmr_nx[i] = r_tmr[i];
            if (w_fault_nx) begin
                w_st_nx[i]  = ST_FAULT;
                w_tmr_nx[i] = '0;
            end else begin
                case (r_st[i])
                    ST_RED: if (w_elig[i]) begin
                        w_st_nx[i]  = ST_GREEN;
                        w_tmr_nx[i] = CNT_W'(1);
                    end
                    ST_GREEN: begin
                        if (!w_go[i] && (r_tmr[i] >= L_MG)) begin
                            w_st_nx[i]  = ST_YELLOW;
                            w_tmr_nx[i] = CNT_W'(1);
                        end else if (r_tmr[i] < L_MG) begin
                            w_tmr_nx[i] = r_tmr[i] + 1'b1;
                        end
                    end
                    ST_YELLOW: begin
                        if (r_tmr[i] >= L_YC) begin
                            w_st_nx[i]  = ST_RED;
                            w_tmr_nx[i] = '0;
                        end else begin
                            w_tmr_nx[i] = r_tmr[i] + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (w_fault_nx) begin
                w_lamp_nx[i] = (w_flash_nx < L_FH) ? LAMP_RED : LAMP_OFF;
            end else begin
                w_lamp_nx[i] = f_lamp(w_st_nx[i]);
            end
        end

        w_clr_ns_nx = w_ns_act ? '0 : ((r_clr_ns >= L_AR) ? r_clr_ns : r_clr_ns + 1'b1);
        w_clr_ew_nx = w_ew_act ? '0 : ((r_clr_ew >= L_AR) ? r_clr_ew : r_clr_ew + 1'b1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                r_st[i]   <= ST_RED;
                r_tmr[i]  <= '0;
                r_lamp[i] <= LAMP_RED;
            end
            r_clr_ns <= L_AR;
            r_clr_ew <= L_AR;
            r_flash  <= '0;
            r_fault  <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_st[i]   <= w_st_nx[i];
                r_tmr[i]  <= w_tmr_nx[i];
                r_lamp[i] <= w_lamp_nx[i];
            end
            r_clr_ns <= w_clr_ns_nx;
            r_clr_ew <= w_clr_ew_nx;
            r_flash  <= w_flash_nx;
            r_fault  <= w_fault_nx;
        end
    end

    assign n_lamp = r_lamp[0];
    assign s_lamp = r_lamp[1];
    assign e_lamp = r_lamp[2];
    assign fault  = r_fault;

endmodule

// File: tb/tb_signal_head_sequencer.sv
// Scoreboard bench for signal_head_sequencer: a time-based reference model predicts each
// cycle's lamps and fault; a monitor pops predictions after every clock edge and compares.
module tb_signal_head_sequencer;

    localparam int MG = 3;
    localparam int YC = 4;
    localparam int AR = 2;
    localparam int FP = 8;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       n_go = 1'b0, s_go = 1'b0, e_go = 1'b0;
    logic [2:0] n_lamp, s_lamp, e_lamp;
    logic       fault;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] q[$];

    // Reference model: lamp colour per approach plus the edge at which it began,
    // the last edge each axis was showing any colour, and the fault edge.
    logic [2:0] m_lamp  [3];
    int         m_since [3];
    int         m_k, m_last_ns, m_last_ew, m_fedge;
    bit         m_fault;

    logic [2:0] prev [3];
    bit         prev_ok = 1'b0;

    signal_head_sequencer #(
        .MIN_GREEN(MG), .YELLOW_CYCLES(YC), .ALL_RED_CYCLES(AR), .FLASH_PERIOD(FP), .CNT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .n_go(n_go), .s_go(s_go), .e_go(e_go),
        .n_lamp(n_lamp), .s_lamp(s_lamp), .e_lamp(e_lamp),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_lamp[i]  = RED;
            m_since[i] = 0;
        end
        m_k = 0; m_last_ns = -1000; m_last_ew = -1000; m_fedge = 0; m_fault = 1'b0;
    endtask

    task automatic model_edge(input logic [2:0] go, output logic [9:0] exp);
        bit busy_ns, busy_ew, ns_clear, ew_clear;
        bit ok [3];
        m_k++;
        if (!m_fault && go[2] && (go[0] || go[1])) begin
            m_fault = 1'b1;
            m_fedge = m_k;
        end
        if (m_fault) begin
            for (int i = 0; i < 3; i++)
                m_lamp[i] = (((m_k - m_fedge) % FP) < FP / 2) ? RED : OFF;
        end else begin
            busy_ns  = (m_lamp[0] != RED) || (m_lamp[1] != RED);
            busy_ew  = (m_lamp[2] != RED);
            ns_clear = (m_k - m_last_ns - 1) >= AR;
            ew_clear = (m_k - m_last_ew - 1) >= AR;
            ok[0] = go[0] && !busy_ew && ew_clear;
            ok[1] = go[1] && !busy_ew && ew_clear;
            ok[2] = go[2] && !busy_ns && ns_clear && !(ok[0] || ok[1]);
            for (int i = 0; i < 3; i++) begin
                if (m_lamp[i] == RED && ok[i]) begin
                    m_lamp[i] = GRN; m_since[i] = m_k;
                end else if (m_lamp[i] == GRN && !go[i] && (m_k - m_since[i]) >= MG) begin
                    m_lamp[i] = YEL; m_since[i] = m_k;
                end else if (m_lamp[i] == YEL && (m_k - m_since[i]) >= YC) begin
                    m_lamp[i] = RED; m_since[i] = m_k;
                end
            end
            if (busy_ns) m_last_ns = m_k;
            if (busy_ew) m_last_ew = m_k;
        end
        exp = {m_lamp[0], m_lamp[1], m_lamp[2], m_fault};
    endtask

    // Called at a falling edge; applies one grant vector for the next rising edge.
    task automatic drive(input logic [2:0] go);
        logic [9:0] exp;
        n_go = go[0]; s_go = go[1]; e_go = go[2];
        model_edge(go, exp);
        q.push_back(exp);
        @(negedge clk);
    endtask

    task automatic check_now(input string name, input logic [3:0] act, input logic [3:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // Called at a falling edge; reset lands between clock edges and must act at once.
    task automatic do_reset();
        q.delete();
        #2;
        reset_n = 1'b0;
        n_go = 1'b0; s_go = 1'b0; e_go = 1'b0;
        #1;
        check_now("reset_n_lamp", {1'b0, n_lamp}, {1'b0, RED});
        check_now("reset_s_lamp", {1'b0, s_lamp}, {1'b0, RED});
        check_now("reset_e_lamp", {1'b0, e_lamp}, {1'b0, RED});
        check_now("reset_fault",  {3'b0, fault},  4'b0);
        prev_ok = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    always @(posedge clk) begin
        logic [9:0] ev, av;
        logic [2:0] cur [3];
        #1;
        if (q.size() > 0) begin
            ev = q.pop_front();
            av = {n_lamp, s_lamp, e_lamp, fault};
            n_vec++;
            if (av !== ev) begin
                n_err++;
                $display("FAIL scoreboard t=%0t: got n=%b s=%b e=%b fault=%b, expected n=%b s=%b e=%b fault=%b",
                         $time, av[9:7], av[6:4], av[3:1], av[0], ev[9:7], ev[6:4], ev[3:1], ev[0]);
            end
            cur[0] = n_lamp; cur[1] = s_lamp; cur[2] = e_lamp;
            if (!fault) begin
                if ((e_lamp != RED && (n_lamp != RED || s_lamp != RED))) begin
                    n_err++;
                    $display("FAIL interlock t=%0t: n=%b s=%b e=%b", $time, n_lamp, s_lamp, e_lamp);
                end
                for (int i = 0; i < 3; i++) begin
                    if (!$onehot(cur[i])) begin
                        n_err++;
                        $display("FAIL onehot t=%0t: head %0d lamp=%b", $time, i, cur[i]);
                    end
                    if (prev_ok && prev[i] == GRN && cur[i] == RED) begin
                        n_err++;
                        $display("FAIL green_to_red t=%0t: head %0d", $time, i);
                    end
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (cur[i] != RED && cur[i] != OFF) begin
                        n_err++;
                        $display("FAIL flash_code t=%0t: head %0d lamp=%b", $time, i, cur[i]);
                    end
                end
            end
            for (int i = 0; i < 3; i++) prev[i] = cur[i];
            prev_ok = 1'b1;
        end
    end

    initial begin
        logic [2:0] g;
        model_reset();
        @(negedge clk);
        // Initial reset: outputs must already be in the reset state
        do_reset();

        // Single north pulse: minimum green, exact yellow, back to red
        drive(3'b001);
        repeat (12) drive(3'b000);

        // North hands over to east in the same cycle its grant drops
        do_reset();
        repeat (5) drive(3'b001);
        repeat (14) drive(3'b100);
        repeat (10) drive(3'b000);

        // North and south together, south drops first, then east waits for both
        do_reset();
        repeat (4) drive(3'b011);
        repeat (2) drive(3'b001);
        repeat (14) drive(3'b100);
        repeat (10) drive(3'b000);

        // Conflicting grants: fault latches and flashing persists regardless of grants
        do_reset();
        repeat (2) drive(3'b001);
        drive(3'b101);
        repeat (24) drive(3'($urandom_range(0, 7)));

        // Reset asserted while north is yellow, then normal operation from south
        do_reset();
        drive(3'b001);
        repeat (5) drive(3'b000);
        do_reset();
        repeat (3) drive(3'b010);
        repeat (12) drive(3'b000);

        // Randomized grant streams with held values and rare conflicts
        for (int b = 0; b < 6; b++) begin
            do_reset();
            g = 3'b000;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    g = 3'($urandom_range(0, 7));
                    if (g[2] && (g[0] || g[1]) && $urandom_range(0, 39) != 0) g[2] = 1'b0;
                end
                drive(g);
            end
        end

        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d predictions never compared", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/signal_head_sequencer.md
Name: signal_head_sequencer

Overview:
- Downstream stage of the intersection traffic controller: consumes its per-approach grant signals (n_go, s_go, e_go) and drives the physical red/yellow/green lamp heads.
- Inserts minimum green, fixed yellow and all-red clearance intervals.
- Enforces a hardware conflict interlock between the N/S axis and the E axis.
- Latches a fault, with flashing red, if the controller ever grants conflicting approaches together.

Parameters:
MIN_GREEN, 3, minimum cycles an approach stays GREEN once entered (>=1)
YELLOW_CYCLES, 4, exact cycles spent in YELLOW (>=1)
ALL_RED_CYCLES, 2, cycles the conflicting axis must be fully red before a green (>=1)
FLASH_PERIOD, 8, fault flash period in cycles (even, >=2)
CNT_W, 8, width of all internal timers; must hold max(MIN_GREEN, YELLOW_CYCLES, ALL_RED_CYCLES, FLASH_PERIOD)

Ports:
clk  input  1  single clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
n_go  input  1  north grant from controller
s_go  input  1  south grant from controller
e_go  input  1  east grant from controller
n_lamp  output  3  {red,yellow,green} north head
s_lamp  output  3  {red,yellow,green} south head
e_lamp  output  3  {red,yellow,green} east head
fault  output  1  latched conflicting-grant fault

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-sequence):
  - every lamp = 3'b100 (red); fault = 0; all approach FSMs in RED.
  - Clearance timers preset to ALL_RED_CYCLES (saturated), so a grant can go green at the first edge after reset release.
- Axes: N and S form the NS axis and never conflict with each other. E forms the EW axis and conflicts with both N and S.
- Per-approach FSM, states RED, GREEN, YELLOW. Lamp encoding: RED=100, GREEN=001, YELLOW=010.
- RED->GREEN on an edge where all of the following hold:
  - own go = 1;
  - no conflicting approach in GREEN/YELLOW;
  - the conflicting axis clearance timer >= ALL_RED_CYCLES;
  - no fault.
  - Latency: the lamp shows green in the cycle after the qualifying edge.
- GREEN->YELLOW when go = 0 and green timer >= MIN_GREEN.
  - Green timer = 1 in the first green cycle and saturates.
  - A go drop before MIN_GREEN is held off until the minimum is reached.
- YELLOW->RED after exactly YELLOW_CYCLES cycles in YELLOW.
  - go re-asserted during YELLOW is ignored until RED, then re-evaluated normally (minimum 1 cycle of RED).
- Clearance timer, one per axis:
  - cleared to 0 while any approach of that axis is GREEN/YELLOW;
  - otherwise increments each cycle, saturating at ALL_RED_CYCLES.
  - The NS timer gates E; the EW timer gates N and S.
- Simultaneous eligible requests from both axes on the same edge: NS wins; E waits.
  - Unreachable with a correct controller, since conflicting simultaneous go is a fault.
- Fault:
  - Trigger: any sampled edge with e_go & (n_go | s_go).
  - The fault sets on that edge and all FSMs are forced to a FAULT override.
  - Lamps go straight to flash with no yellow: red on (100) for FLASH_PERIOD/2 cycles, then all off (000) for FLASH_PERIOD/2, repeating.
  - fault = 1 and sticky; only reset clears it.
  - The flash counter starts at 0 on the fault edge, so the first fault cycle shows red.
- Safety invariants, asserted in bench:
  - e_lamp non-red implies n_lamp and s_lamp red, and vice versa.
  - Each lamp is exactly one-hot except 000 during fault flash.
  - Green is never directly followed by red.
- All timers are saturating and never wrap.

Test Plan:
- Reset release, n_go=1 at edge 1 -> n_lamp=001 from cycle 2; s/e stay 100; fault=0.
- n_go pulse 1 cycle -> green held 3 cycles (MIN_GREEN), yellow exactly 4 cycles, then 100.
- N green, n_go drops, e_go rises in the same cycle -> e_lamp stays 100 through N yellow (4) plus all-red (2); e_lamp=001 no earlier than 7 cycles after N leaves green.
- n_go and s_go together -> both heads 001 the next cycle; e_go after both drop -> E waits for the later of the two to clear plus 2 cycles.
- e_go=1 and n_go=1 on one edge -> fault=1 the next cycle; all lamps flash 100 for 4 cycles, 000 for 4, repeating; further go changes ignored.
- Assert reset_n=0 mid-yellow -> all lamps 100 and fault=0 immediately, without waiting for a clock edge; normal sequencing after release.
